mod_counter_arbiter: RTL and testbench

Shares one modulo-counter engine between several requesters. Each requester supplies its own modulus and wrap count. A round-robin arbiter grants the engine to one requester at a time. A small FSM loads that requester's configuration, runs the count for the requested number of wraps, then pulses completion. It sits above the modulo-counter datapath and replaces per-client counters in the Week 12+ designs.

---
 rtl/mod_counter_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mod_counter_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_arbiter.sv
// Round-robin shared modulo-counter engine: requesters take turns owning one counter.
// Define MOD_CTR_PRIORITY_EN to replace round-robin arbitration with fixed lowest-index priority.
module mod_counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int WRAPW = 4
) (
  input  logic                   Store,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ*WIDTH-1:0]  Mod,
  input  logic [NREQ*WRAPW-1:0]  Wraps,
  output logic [NREQ-1:0]        Grant,
  output logic [NREQ-1:0]        Done,
  output logic [WIDTH-1:0]       B,
  output logic                   Q,
  output logic                   Busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  modCap_q, modCap_d;
  logic [WRAPW-1:0]  wrapsCap_q, wrapsCap_d;
  logic [WRAPW-1:0]  wrapCnt_q, wrapCnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              busy_q, busy_d;

  logic [PW-1:0]     winner;
  logic              found;
  logic              anyReq;
  logic              ownerReq;
  logic [WIDTH-1:0]  modSel;
  logic [WRAPW-1:0]  wrapsSel;
  logic [WIDTH-1:0]  termVal;
  logic [WRAPW-1:0]  wrapInc;
  logic              atTerm;
  logic              lastWrap;

`ifndef MOD_CTR_PRIORITY_EN
  function automatic logic [PW-1:0] rrIdx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction
`endif

  // Winner search: lowest index in priority build, otherwise upward from pointer+1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef MOD_CTR_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && Req[i]) begin
        winner = PW'(i);
        found  = 1'b1;
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && Req[rrIdx(ptr_q, k)]) begin
        winner = rrIdx(ptr_q, k);
        found  = 1'b1;
      end
    end
`endif
  end

  assign anyReq   = |Req;
  assign ownerReq = Req[owner_q];
  assign modSel   = Mod[int'(owner_q)*WIDTH +: WIDTH];
  assign wrapsSel = Wraps[int'(owner_q)*WRAPW +: WRAPW];

  // Modulus 0 wraps naturally to all-ones, giving a full 2^WIDTH count.
  assign termVal  = modCap_q - WIDTH'(1);
  assign atTerm   = (b_q == termVal);
  assign wrapInc  = wrapCnt_q + WRAPW'(1);
  assign lastWrap = (wrapInc == wrapsCap_q);

  always_ff @(posedge Store or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      b_q        <= '0;
      modCap_q   <= '0;
      wrapsCap_q <= '0;
      wrapCnt_q  <= '0;
      ptr_q      <= PW'(NREQ - 1);
      owner_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      b_q        <= b_d;
      modCap_q   <= modCap_d;
      wrapsCap_q <= wrapsCap_d;
      wrapCnt_q  <= wrapCnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
    end
  end

  // A dropped owner request aborts LOAD or RUN straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (anyReq) state_d = LOAD;
      end
      LOAD: begin
        if (!ownerReq)             state_d = IDLE;
        else if (wrapsSel == '0)   state_d = DONE;
        else                       state_d = RUN;
      end
      RUN: begin
        if (!ownerReq)             state_d = IDLE;
        else if (atTerm && lastWrap) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    b_d        = b_q;
    modCap_d   = modCap_q;
    wrapsCap_d = wrapsCap_q;
    wrapCnt_d  = wrapCnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;

    case (state_q)
      IDLE: begin
        if (anyReq) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
        end
      end
      LOAD: begin
        modCap_d   = modSel;
        wrapsCap_d = wrapsSel;
        b_d        = '0;
        wrapCnt_d  = '0;
      end
      RUN: begin
        if (atTerm) begin
          b_d       = '0;
          wrapCnt_d = wrapInc;
        end else begin
          b_d = b_q + WIDTH'(1);
        end
      end
      default: ;
    endcase

    // Completion and abort both hand the pointer to the owner so it goes last next time.
    if (state_q != IDLE && state_d == IDLE) begin
      grant_d = '0;
      b_d     = '0;
      ptr_d   = owner_q;
    end

    done_d = (state_d == DONE) ? grant_q : '0;
    busy_d = (state_d != IDLE);
  end

  assign Grant = grant_q;
  assign Done  = done_q;
  assign B     = b_q;
  assign Busy  = busy_q;
  assign Q     = (state_q == RUN) && atTerm;

endmodule

// File: tb/tb_mod_counter_arbiter.sv
// Scoreboard bench for mod_counter_arbiter: a job model pushes per-cycle expectations,
// each test task pops and compares them one clock at a time.
module tb_mod_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 3;
  localparam int WRAPW = 4;

  logic                  Store = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       Req;
  logic [NREQ*WIDTH-1:0] Mod;
  logic [NREQ*WRAPW-1:0] Wraps;
  logic [NREQ-1:0]       Grant;
  logic [NREQ-1:0]       Done;
  logic [WIDTH-1:0]      B;
  logic                  Q;
  logic                  Busy;

  typedef struct packed {
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic [WIDTH-1:0] b;
    logic             q;
    logic             busy;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  exp_t obs;
  int   numChecks = 0;
  int   numFails  = 0;
  int   tbPtr     = NREQ - 1;

  mod_counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WRAPW(WRAPW)) dut (
    .Store (Store),
    .Reset (Reset),
    .Req   (Req),
    .Mod   (Mod),
    .Wraps (Wraps),
    .Grant (Grant),
    .Done  (Done),
    .B     (B),
    .Q     (Q),
    .Busy  (Busy)
  );

  always #5 Store = ~Store;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int pickWinner(input logic [NREQ-1:0] r, input int ptr);
`ifdef MOD_CTR_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  function void pushCycle(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d, input int b,
                          input logic q, input logic busy);
    exp_t x;
    x.grant = g;
    x.done  = d;
    x.b     = b[WIDTH-1:0];
    x.q     = q;
    x.busy  = busy;
    expQ.push_back(x);
  endfunction

  // One full job: LOAD, Mod_eff*Wraps RUN cycles, DONE, then the trailing IDLE cycle.
  function void pushJob(input int owner, input int mod, input int wraps);
    logic [NREQ-1:0] g;
    int modEff;
    g      = NREQ'(1) << owner;
    modEff = (mod == 0) ? (1 << WIDTH) : mod;
    pushCycle(g, '0, 0, 1'b0, 1'b1);
    for (int w = 0; w < wraps; w++)
      for (int c = 0; c < modEff; c++)
        pushCycle(g, '0, c, (c == modEff - 1), 1'b1);
    pushCycle(g, g, 0, 1'b0, 1'b1);
    pushCycle('0, '0, 0, 1'b0, 1'b0);
  endfunction

  task automatic test_reset();
    int w;
    Reset = 1'b0;
    Req   = '0;
    Mod   = '0;
    Wraps = '0;
    repeat (2) @(posedge Store);
    #1;
    obs = {Grant, Done, B, Q, Busy};
    numChecks++;
    if (obs !== '0) begin
      numFails++;
      $display("[TB] FAIL reset_state: got %b required %b", obs, 13'b0);
    end
    Reset = 1'b1;

    Req[2] = 1'b1;
    Mod[2*WIDTH +: WIDTH]   = 3'd5;
    Wraps[2*WRAPW +: WRAPW] = 4'd3;
    w = pickWinner(Req, tbPtr);
    pushJob(w, 5, 3);
    for (int n = 0; n < 5; n++) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL reset_prerun: got %b required %b", obs, e);
      end
    end
    expQ.delete();

    #2 Reset = 1'b0;
    #1;
    obs = {Grant, Done, B, Q, Busy};
    numChecks++;
    if (obs !== '0) begin
      numFails++;
      $display("[TB] FAIL reset_async_midrun: got %b required %b", obs, 13'b0);
    end
    tbPtr = NREQ - 1;
    @(posedge Store); #1;
    obs = {Grant, Done, B, Q, Busy};
    numChecks++;
    if (obs !== '0) begin
      numFails++;
      $display("[TB] FAIL reset_held: got %b required %b", obs, 13'b0);
    end
    Reset = 1'b1;
    Req   = 4'b0101;
    Mod[0 +: WIDTH]   = 3'd3;
    Wraps[0 +: WRAPW] = 4'd1;
    w = pickWinner(Req, tbPtr);
    pushJob(w, 3, 1);
    tbPtr = w;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL reset_first_grant: got %b required %b", obs, e);
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
    end
  endtask

  task automatic test_single_job();
    int w;
    int n;
    Req = 4'b0100;
    Mod[2*WIDTH +: WIDTH]   = 3'd5;
    Wraps[2*WRAPW +: WRAPW] = 4'd3;
    w = pickWinner(Req, tbPtr);
    pushJob(w, 5, 3);
    tbPtr = w;
    n = 0;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL single_job cycle %0d: got %b required %b", n, obs, e);
      end
      if (n == 6) begin
        Mod[2*WIDTH +: WIDTH]   = 3'd7;
        Wraps[2*WRAPW +: WRAPW] = 4'd1;
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
      n++;
    end
  endtask

  task automatic test_round_robin();
    int w;
    Req = 4'b1011;
    for (int i = 0; i < NREQ; i++) begin
      Mod[i*WIDTH +: WIDTH]   = 3'd2;
      Wraps[i*WRAPW +: WRAPW] = 4'd1;
    end
    for (int j = 0; j < 6; j++) begin
      w = pickWinner(Req, tbPtr);
      pushJob(w, 2, 1);
      tbPtr = w;
    end
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL round_robin: got %b required %b", obs, e);
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
    end
  endtask

  task automatic test_mod_edges();
    int w;
    Req = 4'b0010;
    Mod[1*WIDTH +: WIDTH]   = 3'd0;
    Wraps[1*WRAPW +: WRAPW] = 4'd1;
    w = pickWinner(Req, tbPtr);
    pushJob(w, 0, 1);
    tbPtr = w;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL mod_zero: got %b required %b", obs, e);
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
    end

    Req = 4'b1000;
    Mod[3*WIDTH +: WIDTH]   = 3'd1;
    Wraps[3*WRAPW +: WRAPW] = 4'd4;
    w = pickWinner(Req, tbPtr);
    pushJob(w, 1, 4);
    tbPtr = w;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL mod_one: got %b required %b", obs, e);
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
    end
  endtask

  task automatic test_wraps_zero();
    int w;
    Req = 4'b0001;
    Mod[0 +: WIDTH]   = 3'd3;
    Wraps[0 +: WRAPW] = 4'd0;
    w = pickWinner(Req, tbPtr);
    pushJob(w, 3, 0);
    tbPtr = w;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL wraps_zero: got %b required %b", obs, e);
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
    end
  endtask

  task automatic test_abort();
    int w;
    int n;
    logic [NREQ-1:0] g;
    Req = 4'b0010;
    Mod[1*WIDTH +: WIDTH]   = 3'd5;
    Wraps[1*WRAPW +: WRAPW] = 4'd2;
    Mod[2*WIDTH +: WIDTH]   = 3'd2;
    Wraps[2*WRAPW +: WRAPW] = 4'd1;
    w = pickWinner(Req, tbPtr);
    g = NREQ'(1) << w;
    pushCycle(g, '0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) pushCycle(g, '0, c, 1'b0, 1'b1);
    pushCycle('0, '0, 0, 1'b0, 1'b0);
    tbPtr = w;
    w = pickWinner(4'b0100, tbPtr);
    pushJob(w, 2, 1);
    tbPtr = w;
    n = 0;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL abort cycle %0d: got %b required %b", n, obs, e);
      end
      if (n == 0) Req[2] = 1'b1;
      if (n == 3) Req[1] = 1'b0;
      if (e.done != '0 && expQ.size() == 1) Req = '0;
      n++;
    end
  endtask

`ifdef MOD_CTR_PRIORITY_EN
  task automatic test_priority();
    int w;
    int doneCount;
    Req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      Mod[i*WIDTH +: WIDTH]   = 3'd2;
      Wraps[i*WRAPW +: WRAPW] = 4'd1;
    end
    for (int j = 0; j < 2; j++) begin
      w = pickWinner(4'b0011, tbPtr);
      pushJob(w, 2, 1);
      tbPtr = w;
    end
    w = pickWinner(4'b0010, tbPtr);
    pushJob(w, 2, 1);
    tbPtr = w;
    doneCount = 0;
    while (expQ.size() > 0) begin
      @(posedge Store); #1;
      e = expQ.pop_front();
      obs = {Grant, Done, B, Q, Busy};
      numChecks++;
      if (obs !== e) begin
        numFails++;
        $display("[TB] FAIL priority: got %b required %b", obs, e);
      end
      if (e.done != '0) begin
        doneCount++;
        if (doneCount == 2) Req[0] = 1'b0;
      end
      if (e.done != '0 && expQ.size() == 1) Req = '0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_mod_edges();
    test_wraps_zero();
    test_abort();
`ifdef MOD_CTR_PRIORITY_EN
    test_priority();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
